// File: rtl/seq_resp_pkg.sv
// Shared types and constants for the request/response sequencer.
package seq_resp_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic DLY2 = 1'b0;
   localparam logic DLY3 = 1'b1;

   localparam int MAX_DLY    = 3;
   localparam int CNT_W_DFLT = 8;

   // Schedule slot masks: slot 0 is the slot currently driving b.
   localparam logic [MAX_DLY-1:0] SLOT_DLY2 = 3'b010;
   localparam logic [MAX_DLY-1:0] SLOT_DLY3 = 3'b100;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/seq_responder.sv
// Delayed request responder with a 3-slot schedule, merge detection and counters.
// Optional one-shot c suppression when SEQ_RESP_FAULT_INJ_EN is defined.
//
// state  | meaning
// IDLE   | schedule empty, nothing pending
// ACTIVE | at least one response pending or being issued
module seq_responder
   import seq_resp_pkg::*;
#(
   parameter int CNT_W = CNT_W_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             a,
   input  logic             delay_sel,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic [CNT_W-1:0] resp_cnt,
   output logic [CNT_W-1:0] coll_cnt
`ifdef SEQ_RESP_FAULT_INJ_EN
   ,
   input  logic             fault_inj
`endif
);

   state_t               state_q, state_d;
   logic [MAX_DLY-1:0]   sched_q, sched_d, sched_sh, req_mask;
   logic                 accept, coll, fire, c_d, c_q;

   always_comb begin
      accept   = en & a;
      sched_sh = {1'b0, sched_q[MAX_DLY-1:1]};
      req_mask = '0;
      if (accept) begin
         req_mask = (delay_sel == DLY3) ? SLOT_DLY3 : SLOT_DLY2;
      end
      // A request landing on an already-occupied slot merges into that pulse.
      coll    = |(sched_sh & req_mask);
      sched_d = sched_sh | req_mask;
      fire    = sched_d[0];
   end

`ifdef SEQ_RESP_FAULT_INJ_EN
   logic armed_q, armed_d;

   always_comb begin
      c_d     = fire & ~armed_q;
      armed_d = armed_q | fault_inj;
      if (fire && armed_q) begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
      end
   end
`else
   always_comb begin
      c_d = fire;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if ((sched_d == '0) && !accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sched_q <= '0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         sched_q <= sched_d;
         c_q     <= c_d;
      end
   end

   assign b    = sched_q[0];
   assign c    = c_q;
   assign busy = (state_q == ACTIVE);

   sat_counter #(.W(CNT_W)) u_resp_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fire),
      .count (resp_cnt)
   );

   sat_counter #(.W(CNT_W)) u_coll_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (coll),
      .count (coll_cnt)
   );

endmodule
